// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for four requesters driving a 2-to-4 decoder (address1:address0, enable).
// Grants are registered, held while requested, and rotated after MAX_HOLD cycles when others wait.
module rr_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       halt,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic [7:0] grant_count
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDXW  = 2;
  localparam int unsigned HOLDW = 4;
  localparam int unsigned CNTW  = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [IDXW-1:0]   addr;
  logic [IDXW-1:0]   last;
  logic [HOLDW-1:0]  hold_cnt;

  logic [IDXW-1:0]   pivot;
  logic [IDXW-1:0]   winner;
  logic [IDXW-1:0]   idx;
  logic              found;
  logic [NREQ-1:0]   others;
  logic              hold_max;
  logic              take;
  logic              drop;
  logic              hold_inc;
  logic [CNTW-1:0]   cnt_next;

  assign address0 = addr[0];
  assign address1 = addr[1];

  // Round-robin scan starting just after the pivot, pivot itself last.
  always_comb begin
    pivot  = (state == GRANT) ? addr : last;
    winner = pivot;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      idx = pivot + IDXW'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Decide this edge's action: take a (new) winner, drop the grant, or keep holding.
  always_comb begin
    others   = req & ~(NREQ'(1) << addr);
    hold_max = (hold_cnt == HOLDW'(MAX_HOLD));
    cnt_next = (grant_count == {CNTW{1'b1}}) ? grant_count : grant_count + CNTW'(1);
    take     = 1'b0;
    drop     = 1'b0;
    hold_inc = 1'b0;
    case (state)
      IDLE: begin
        take = !halt && (|req);
      end
      GRANT: begin
        if (halt) begin
          drop = 1'b1;
        end else if (!req[addr]) begin
          take = |others;
          drop = ~(|others);
        end else if (hold_max) begin
          take = |others;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      enable      <= 1'b0;
      addr        <= '0;
      last        <= IDXW'(NREQ - 1);
      hold_cnt    <= '0;
      grant_count <= '0;
    end else if (take) begin
      state       <= GRANT;
      enable      <= 1'b1;
      addr        <= winner;
      last        <= winner;
      hold_cnt    <= HOLDW'(1);
      grant_count <= cnt_next;
    end else if (drop) begin
      state       <= IDLE;
      enable      <= 1'b0;
    end else if (hold_inc) begin
      hold_cnt    <= hold_cnt + HOLDW'(1);
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: a behavioural model queues expected outputs per edge.
module tb_rr_decoder_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       halt;
  logic       address0;
  logic       address1;
  logic       enable;
  logic [7:0] grant_count;

  int tests_run;
  int tests_failed;

  // Reference model state
  bit m_grant;
  int m_addr;
  int m_last;
  int m_hold;
  int m_cnt;

  typedef struct packed {
    logic       en;
    logic [1:0] addr;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .halt       (halt),
    .address0   (address0),
    .address1   (address1),
    .enable     (enable),
    .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    tests_run++;
    if (got != expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  function automatic int dut_addr();
    return int'({address1, address0});
  endfunction

  task automatic model_reset();
    m_grant = 1'b0;
    m_addr  = 0;
    m_last  = 3;
    m_hold  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_start(input int w);
    m_grant = 1'b1;
    m_addr  = w;
    m_last  = w;
    m_hold  = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_step(input logic [3:0] r, input logic h);
    int p;
    int w;
    bit other;
    p = m_grant ? m_addr : m_last;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && r[(p + k) % 4]) w = (p + k) % 4;
    end
    other = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != m_addr && r[k]) other = 1'b1;
    end
    if (!m_grant) begin
      if (!h && r != 4'b0) model_start(w);
    end else if (h) begin
      m_grant = 1'b0;
    end else if (!r[m_addr]) begin
      if (other) model_start(w);
      else m_grant = 1'b0;
    end else if (m_hold == int'(MAX_HOLD)) begin
      if (other) model_start(w);
    end else begin
      m_hold++;
    end
  endtask

  // Drive at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input logic [3:0] r, input logic h);
    exp_t e;
    req  = r;
    halt = h;
    model_step(r, h);
    e.en   = m_grant;
    e.addr = 2'(m_addr);
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("enable", int'(enable), int'(e.en));
    check("address", dut_addr(), int'(e.addr));
    check("grant_count", int'(grant_count), int'(e.cnt));
    @(negedge clk);
  endtask

  initial begin
    int base;
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    req     = 4'b0;
    halt    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_enable", int'(enable), 0);
    check("rst_address", dut_addr(), 0);
    check("rst_count", int'(grant_count), 0);
    reset_n = 1'b1;

    // Start on 1, hold MAX_HOLD cycles, rotate to 3 without a gap
    step(4'b1010, 1'b0);
    check("first_addr", dut_addr(), 1);
    check("first_count", int'(grant_count), 1);
    repeat (3) step(4'b1010, 1'b0);
    check("held_addr", dut_addr(), 1);
    step(4'b1010, 1'b0);
    check("rotate_addr", dut_addr(), 3);
    check("rotate_count", int'(grant_count), 2);

    // All requesting: fair rotation
    repeat (20) step(4'b1111, 1'b0);

    // Release with a single other requester, then release entirely
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    check("grant2_addr", dut_addr(), 2);
    step(4'b0001, 1'b0);
    check("switch_addr", dut_addr(), 0);
    check("switch_enable", int'(enable), 1);
    step(4'b0000, 1'b0);
    check("release_enable", int'(enable), 0);

    // Halt during a grant, halt held, then resume
    step(4'b0100, 1'b0);
    base = int'(grant_count);
    step(4'b0100, 1'b1);
    check("halt_enable", int'(enable), 0);
    repeat (3) step(4'b0110, 1'b1);
    check("halt_frozen_count", int'(grant_count), base);
    step(4'b0100, 1'b0);
    check("resume_addr", dut_addr(), 2);
    check("resume_count", int'(grant_count), base + 1);

    // Single long grant counts once
    step(4'b0000, 1'b0);
    base = int'(grant_count);
    repeat (300) step(4'b0001, 1'b0);
    check("long_grant_count", int'(grant_count), base + 1);

    // Saturation of the grant counter
    for (int i = 0; i < 260; i++) begin
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
    end
    check("sat_count", int'(grant_count), 255);

    // Asynchronous reset mid-grant, then first grant goes to lowest index
    step(4'b0001, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_enable", int'(enable), 0);
    check("async_rst_count", int'(grant_count), 0);
    model_reset();
    req = 4'b1100;
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1100, 1'b0);
    check("post_rst_addr", dut_addr(), 2);
    check("post_rst_count", int'(grant_count), 1);
    repeat (10) step(4'b1100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
